dmem_axil_master: RTL and testbench

Data-memory bus master at the core's MEM stage. Accepts one load/store request from the pipeline, runs it as a single AXI4-Lite transaction, and returns read data plus a one-cycle `mem_done_o` pulse. It is the responder on the `mem_req` / `mem_done` handshake: the hazard unit stalls EX/MEM and MEM/WB while `mem_req && !mem_done`.

---
 rtl/params_pkg.sv | 26 ++
 rtl/dmem_axil_master.sv | 160 ++++++++++++++++
 tb/tb_dmem_axil_master.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/params_pkg.sv
// Shared types for the data-memory AXI4-Lite master: response codes, FSM states
// and a response-classification helper.
package params_pkg;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'b00,
        AXIL_RESP_EXOKAY = 2'b01,
        AXIL_RESP_SLVERR = 2'b10,
        AXIL_RESP_DECERR = 2'b11
    } axil_resp_t;

    typedef enum logic [2:0] {
        DMEM_IDLE      = 3'd0,
        DMEM_WRITE     = 3'd1,
        DMEM_READ_ADDR = 3'd2,
        DMEM_READ_DATA = 3'd3,
        DMEM_DONE      = 3'd4
    } dmem_state_t;

    // Anything other than OKAY (SLVERR, DECERR, and EXOKAY which a non-exclusive
    // access must never get) is reported to the pipeline as an access fault.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (axil_resp_t'(resp) != AXIL_RESP_OKAY);
    endfunction

endpackage

// File: rtl/dmem_axil_master.sv
// MEM-stage data-memory master: turns one held load/store request into a single
// AXI4-Lite transaction and answers with a one-cycle done pulse.
module dmem_axil_master
    import params_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    mem_req_i,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wstrb_i,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_done_o,
    output logic                    mem_err_o,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr_o,
    output logic                    m_axil_awvalid_o,
    input  logic                    m_axil_awready_i,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb_o,
    output logic                    m_axil_wvalid_o,
    input  logic                    m_axil_wready_i,
    input  logic [1:0]              m_axil_bresp_i,
    input  logic                    m_axil_bvalid_i,
    output logic                    m_axil_bready_o,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr_o,
    output logic                    m_axil_arvalid_o,
    input  logic                    m_axil_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata_i,
    input  logic [1:0]              m_axil_rresp_i,
    input  logic                    m_axil_rvalid_i,
    output logic                    m_axil_rready_o
);

    dmem_state_t             r_state;
    dmem_state_t             w_state_next;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic                    r_err;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;

    // Channel controls are decoded from state and sticky flags only, so no
    // ready/valid input ever reaches an output combinationally.
    assign m_axil_awvalid_o = (r_state == DMEM_WRITE) && !r_aw_done;
    assign m_axil_wvalid_o  = (r_state == DMEM_WRITE) && !r_w_done;
    assign m_axil_bready_o  = (r_state == DMEM_WRITE);
    assign m_axil_arvalid_o = (r_state == DMEM_READ_ADDR);
    assign m_axil_rready_o  = (r_state == DMEM_READ_DATA);
    assign mem_done_o       = (r_state == DMEM_DONE);
    assign mem_err_o        = (r_state == DMEM_DONE) && r_err;

    assign m_axil_awaddr_o  = r_addr;
    assign m_axil_araddr_o  = r_addr;
    assign m_axil_wdata_o   = r_wdata;
    assign m_axil_wstrb_o   = r_wstrb;
    assign mem_rdata_o      = r_rdata;

    assign w_aw_hs = m_axil_awvalid_o && m_axil_awready_i;
    assign w_w_hs  = m_axil_wvalid_o  && m_axil_wready_i;
    assign w_b_hs  = m_axil_bready_o  && m_axil_bvalid_i;
    assign w_ar_hs = m_axil_arvalid_o && m_axil_arready_i;
    assign w_r_hs  = m_axil_rready_o  && m_axil_rvalid_i;

    // Next-state decode; DONE always returns to IDLE so a request still held
    // high on its completion cycle is not accepted a second time.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DMEM_IDLE: begin
                if (mem_req_i) begin
                    w_state_next = mem_we_i ? DMEM_WRITE : DMEM_READ_ADDR;
                end else begin
                    w_state_next = DMEM_IDLE;
                end
            end
            DMEM_WRITE: begin
                if (w_b_hs) begin
                    w_state_next = DMEM_DONE;
                end else begin
                    w_state_next = DMEM_WRITE;
                end
            end
            DMEM_READ_ADDR: begin
                if (w_ar_hs) begin
                    w_state_next = DMEM_READ_DATA;
                end else begin
                    w_state_next = DMEM_READ_ADDR;
                end
            end
            DMEM_READ_DATA: begin
                if (w_r_hs) begin
                    w_state_next = DMEM_DONE;
                end else begin
                    w_state_next = DMEM_READ_DATA;
                end
            end
            DMEM_DONE: w_state_next = DMEM_IDLE;
            default:   w_state_next = DMEM_IDLE;
        endcase
    end

    // State, request latches, sticky handshake flags and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= DMEM_IDLE;
            r_addr    <= {ADDR_WIDTH{1'b0}};
            r_wdata   <= {DATA_WIDTH{1'b0}};
            r_wstrb   <= {(DATA_WIDTH/8){1'b0}};
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                DMEM_IDLE: begin
                    if (mem_req_i) begin
                        r_addr    <= mem_addr_i;
                        r_wdata   <= mem_wdata_i;
                        r_wstrb   <= mem_wstrb_i;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                end
                DMEM_WRITE: begin
                    if (w_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if (w_b_hs) begin
                        r_err <= resp_is_err(m_axil_bresp_i);
                    end
                end
                DMEM_READ_DATA: begin
                    if (w_r_hs) begin
                        r_rdata <= m_axil_rdata_i;
                        r_err   <= resp_is_err(m_axil_rresp_i);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axil_master.sv
// Directed bench for dmem_axil_master with a configurable-latency AXI4-Lite slave.
module tb_dmem_axil_master;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic [3:0]  mem_wstrb_i = 4'h0;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic        mem_err_o;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;

    int          cfg_aw_delay = 0, cfg_w_delay = 0, cfg_ar_delay = 0, cfg_b_delay = 0, cfg_r_delay = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    bit aw_got = 1'b0, w_got = 1'b0, b_pend = 1'b0, r_pend = 1'b0;
    bit hs_aw = 1'b0, hs_w = 1'b0, hs_b = 1'b0, hs_ar = 1'b0, hs_r = 1'b0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [31:0] cap_awaddr = 32'h0, cap_wdata = 32'h0, cap_araddr = 32'h0;
    logic [31:0] last_awaddr = 32'h0, last_wdata = 32'h0, last_araddr = 32'h0;

    always #5 clk = ~clk;

    dmem_axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_wstrb_i(mem_wstrb_i),
        .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o), .mem_err_o(mem_err_o),
        .m_axil_awaddr_o(awaddr), .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
        .m_axil_wdata_o(wdata), .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
        .m_axil_wready_i(wready),
        .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
        .m_axil_araddr_o(araddr), .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
        .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp), .m_axil_rvalid_i(rvalid),
        .m_axil_rready_o(rready)
    );

    // Slave: at each falling edge, commit handshakes that occurred at the rising
    // edge just passed, then drive new ready/valid values and predict the next ones.
    initial begin : slave
        forever begin
            @(negedge clk);
            if (rst_i) begin
                awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 1'b0; w_got = 1'b0; b_pend = 1'b0; r_pend = 1'b0;
                hs_aw = 1'b0; hs_w = 1'b0; hs_b = 1'b0; hs_ar = 1'b0; hs_r = 1'b0;
            end else begin
                if (hs_aw) begin n_aw++; aw_got = 1'b1; last_awaddr = cap_awaddr; end
                if (hs_w)  begin n_w++;  w_got = 1'b1;  last_wdata = cap_wdata;   end
                if (aw_got && w_got) begin b_pend = 1'b1; b_cnt = 0; aw_got = 1'b0; w_got = 1'b0; end
                if (hs_b)  begin n_b++;  b_pend = 1'b0; end
                if (hs_ar) begin n_ar++; r_pend = 1'b1; r_cnt = 0; last_araddr = cap_araddr; end
                if (hs_r)  begin n_r++;  r_pend = 1'b0; end

                if (awvalid) begin awready = (aw_cnt >= cfg_aw_delay); aw_cnt++; end
                else begin awready = 1'b0; aw_cnt = 0; end
                if (wvalid) begin wready = (w_cnt >= cfg_w_delay); w_cnt++; end
                else begin wready = 1'b0; w_cnt = 0; end
                if (arvalid) begin arready = (ar_cnt >= cfg_ar_delay); ar_cnt++; end
                else begin arready = 1'b0; ar_cnt = 0; end
                if (b_pend) begin bvalid = (b_cnt >= cfg_b_delay); b_cnt++; end
                else begin bvalid = 1'b0; end
                if (r_pend) begin rvalid = (r_cnt >= cfg_r_delay); r_cnt++; end
                else begin rvalid = 1'b0; end
                bresp = cfg_bresp;
                rresp = cfg_rresp;
                rdata = rvalid ? cfg_rdata : 32'h0;

                hs_aw = awvalid && awready; cap_awaddr = awaddr;
                hs_w  = wvalid && wready;   cap_wdata  = wdata;
                hs_b  = bvalid && bready;
                hs_ar = arvalid && arready; cap_araddr = araddr;
                hs_r  = rvalid && rready;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issues one request, holds it until done (bounded), then drops it.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int budget, output int cycles,
                          output logic err, output logic [31:0] rd, output bit tmo);
        mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd; mem_wstrb_i = ws;
        cycles = 0; err = 1'b0; rd = 32'h0; tmo = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            tick();
            if (mem_done_o) begin
                cycles = n; err = mem_err_o; rd = mem_rdata_o; tmo = 1'b0;
                break;
            end
        end
        mem_req_i = 1'b0; mem_we_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b00000) begin
            n_fail++; $display("FAIL reset_handshake: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        n_checks++;
        if ({mem_done_o, mem_err_o} !== 2'b00) begin
            n_fail++; $display("FAIL reset_done_err: got %b expected 00", {mem_done_o, mem_err_o});
        end
        n_checks++;
        if ({awaddr, araddr, wdata, wstrb, mem_rdata_o} !== 132'h0) begin
            n_fail++; $display("FAIL reset_data: aw=%h ar=%h wd=%h ws=%h rd=%h expected all 0", awaddr, araddr, wdata, wstrb, mem_rdata_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_store_zero_wait();
        int base_aw, base_b;
        base_aw = n_aw; base_b = n_b;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_1000;
        mem_wdata_i = 32'hDEAD_BEEF; mem_wstrb_i = 4'hF;
        tick();
        n_checks++;
        if ({awvalid, wvalid, bready, mem_done_o} !== 4'b1110) begin
            n_fail++; $display("FAIL store_c1_ctrl: got %b expected 1110", {awvalid, wvalid, bready, mem_done_o});
        end
        n_checks++;
        if ({awaddr, wdata, wstrb} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
            n_fail++; $display("FAIL store_c1_payload: got %h %h %h expected 00001000 deadbeef f", awaddr, wdata, wstrb);
        end
        tick();
        n_checks++;
        if ({awvalid, wvalid, bready, mem_done_o} !== 4'b0010) begin
            n_fail++; $display("FAIL store_c2_ctrl: got %b expected 0010", {awvalid, wvalid, bready, mem_done_o});
        end
        tick();
        n_checks++;
        if ({mem_done_o, mem_err_o, bready} !== 3'b100) begin
            n_fail++; $display("FAIL store_c3_done: got %b expected 100", {mem_done_o, mem_err_o, bready});
        end
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        tick();
        n_checks++;
        if ({mem_done_o, 8'(n_aw - base_aw), 8'(n_b - base_b)} !== {1'b0, 8'd1, 8'd1}) begin
            n_fail++; $display("FAIL store_c4_counts: done=%b aw=%0d b=%0d expected done=0 aw=1 b=1", mem_done_o, n_aw - base_aw, n_b - base_b);
        end
    endtask

    task automatic test_aw_late();
        logic [6:1] e_aw, e_w, e_dn;
        int base_aw, base_w;
        e_aw = 6'b001111; e_w = 6'b000001; e_dn = 6'b100000;
        base_aw = n_aw; base_w = n_w;
        cfg_aw_delay = 3;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_1010;
        mem_wdata_i = 32'hA5A5_5A5A; mem_wstrb_i = 4'hC;
        for (int c = 1; c <= 6; c++) begin
            tick();
            n_checks++;
            if ({awvalid, wvalid, mem_done_o} !== {e_aw[c], e_w[c], e_dn[c]}) begin
                n_fail++; $display("FAIL aw_late_c%0d: got aw/w/done=%b expected %b", c, {awvalid, wvalid, mem_done_o}, {e_aw[c], e_w[c], e_dn[c]});
            end
            if (c == 6) begin mem_req_i = 1'b0; mem_we_i = 1'b0; end
        end
        tick();
        n_checks++;
        if ({mem_done_o, 8'(n_aw - base_aw), 8'(n_w - base_w), last_awaddr} !== {1'b0, 8'd1, 8'd1, 32'h0000_1010}) begin
            n_fail++; $display("FAIL aw_late_after: done=%b aw=%0d w=%0d addr=%h expected 0 1 1 00001010", mem_done_o, n_aw - base_aw, n_w - base_w, last_awaddr);
        end
        cfg_aw_delay = 0;
    endtask

    task automatic test_load_wait();
        int cyc; logic err; logic [31:0] rd; bit tmo;
        cfg_r_delay = 5; cfg_rdata = 32'h1234_5678; cfg_rresp = 2'b00;
        do_req(1'b0, 32'h0000_2004, 32'h0, 4'h0, 30, cyc, err, rd, tmo);
        n_checks++;
        if ({tmo, 8'(cyc), err, rd} !== {1'b0, 8'd8, 1'b0, 32'h1234_5678}) begin
            n_fail++; $display("FAIL load_wait: tmo=%b cycles=%0d err=%b rdata=%h expected 0 8 0 12345678", tmo, cyc, err, rd);
        end
        n_checks++;
        if (last_araddr !== 32'h0000_2004) begin
            n_fail++; $display("FAIL load_araddr: got %h expected 00002004", last_araddr);
        end
        cfg_r_delay = 0;
        tick();
        do_req(1'b1, 32'h0000_2008, 32'h0F0F_0F0F, 4'h3, 20, cyc, err, rd, tmo);
        tick();
        n_checks++;
        if ({tmo, 8'(cyc), mem_rdata_o} !== {1'b0, 8'd3, 32'h1234_5678}) begin
            n_fail++; $display("FAIL load_hold_over_store: tmo=%b cycles=%0d rdata=%h expected 0 3 12345678", tmo, cyc, mem_rdata_o);
        end
    endtask

    task automatic test_errors();
        int cyc; logic err; logic [31:0] rd; bit tmo;
        cfg_rresp = 2'b10; cfg_rdata = 32'hBAD0_BAD0;
        do_req(1'b0, 32'h0000_3000, 32'h0, 4'h0, 20, cyc, err, rd, tmo);
        n_checks++;
        if ({tmo, 8'(cyc), err, rd} !== {1'b0, 8'd3, 1'b1, 32'hBAD0_BAD0}) begin
            n_fail++; $display("FAIL read_slverr: tmo=%b cycles=%0d err=%b rdata=%h expected 0 3 1 bad0bad0", tmo, cyc, err, rd);
        end
        tick();
        n_checks++;
        if ({mem_done_o, mem_err_o} !== 2'b00) begin
            n_fail++; $display("FAIL slverr_one_cycle: got done/err=%b expected 00", {mem_done_o, mem_err_o});
        end
        cfg_rresp = 2'b00; cfg_rdata = 32'hCAFE_F00D;
        do_req(1'b0, 32'h0000_3004, 32'h0, 4'h0, 20, cyc, err, rd, tmo);
        n_checks++;
        if ({tmo, err, rd} !== {1'b0, 1'b0, 32'hCAFE_F00D}) begin
            n_fail++; $display("FAIL read_okay_after_err: tmo=%b err=%b rdata=%h expected 0 0 cafef00d", tmo, err, rd);
        end
        tick();
        cfg_bresp = 2'b11;
        do_req(1'b1, 32'h0000_3008, 32'h1357_9BDF, 4'hF, 20, cyc, err, rd, tmo);
        n_checks++;
        if ({tmo, 8'(cyc), err} !== {1'b0, 8'd3, 1'b1}) begin
            n_fail++; $display("FAIL store_decerr: tmo=%b cycles=%0d err=%b expected 0 3 1", tmo, cyc, err);
        end
        cfg_bresp = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        int base_aw, base_b, cyc;
        bit seen;
        base_aw = n_aw; base_b = n_b;
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h0000_4000;
        mem_wdata_i = 32'h1111_1111; mem_wstrb_i = 4'hF;
        seen = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (mem_done_o) begin seen = 1'b1; break; end
        end
        n_checks++;
        if ({seen, last_awaddr} !== {1'b1, 32'h0000_4000}) begin
            n_fail++; $display("FAIL b2b_first: done_seen=%b awaddr=%h expected 1 00004000", seen, last_awaddr);
        end
        tick();
        mem_addr_i = 32'h0000_5000; mem_wdata_i = 32'h2222_2222;
        cyc = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (mem_done_o) begin cyc = n; break; end
        end
        mem_req_i = 1'b0; mem_we_i = 1'b0;
        n_checks++;
        if (cyc !== 3) begin
            n_fail++; $display("FAIL b2b_second_latency: got %0d cycles expected 3", cyc);
        end
        for (int n = 0; n < 5; n++) tick();
        n_checks++;
        if ({8'(n_aw - base_aw), 8'(n_b - base_b), last_awaddr, last_wdata} !== {8'd2, 8'd2, 32'h0000_5000, 32'h2222_2222}) begin
            n_fail++; $display("FAIL b2b_txn_count: aw=%0d b=%0d addr=%h wdata=%h expected 2 2 00005000 22222222", n_aw - base_aw, n_b - base_b, last_awaddr, last_wdata);
        end
    endtask

    task automatic test_reset_mid_read();
        int cyc, base_r; logic err; logic [31:0] rd; bit tmo, seen;
        cfg_r_delay = 10; cfg_rdata = 32'h0000_0099;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_6000;
        seen = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (rready) begin seen = 1'b1; break; end
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++; $display("FAIL rst_reach_read_data: rready seen=%b expected 1", seen);
        end
        rst_i = 1'b1; mem_req_i = 1'b0;
        tick();
        n_checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, mem_done_o, mem_err_o} !== 7'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got %b expected 0000000", {awvalid, wvalid, bready, arvalid, rready, mem_done_o, mem_err_o});
        end
        n_checks++;
        if ({awaddr, araddr, wdata, wstrb, mem_rdata_o} !== 132'h0) begin
            n_fail++; $display("FAIL rst_mid_data: aw=%h ar=%h wd=%h ws=%h rd=%h expected all 0", awaddr, araddr, wdata, wstrb, mem_rdata_o);
        end
        rst_i = 1'b0;
        cfg_r_delay = 0; cfg_rdata = 32'h0BAD_C0DE;
        tick();
        base_r = n_r;
        do_req(1'b0, 32'h0000_6004, 32'h0, 4'h0, 20, cyc, err, rd, tmo);
        n_checks++;
        if ({tmo, 8'(cyc), err, rd, last_araddr} !== {1'b0, 8'd3, 1'b0, 32'h0BAD_C0DE, 32'h0000_6004}) begin
            n_fail++; $display("FAIL rst_fresh_read: tmo=%b cycles=%0d err=%b rdata=%h araddr=%h expected 0 3 0 0badc0de 00006004", tmo, cyc, err, rd, last_araddr);
        end
        tick();
        n_checks++;
        if (n_r - base_r !== 1) begin
            n_fail++; $display("FAIL rst_fresh_r_count: got %0d expected 1", n_r - base_r);
        end
    endtask

    initial begin : main
        test_reset();
        test_store_zero_wait();
        tick();
        test_aw_late();
        tick();
        test_load_wait();
        tick();
        test_errors();
        test_back_to_back();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
